// File: rtl/priority_decoder_3x8.sv
// Registered 3-to-8 decoder that holds each accepted pattern for HOLD_CYCLES cycles.
// Defining PRIORITY_DECODER_BUFFER_EN adds a one-entry input buffer that is filled during a hold.
module priority_decoder_3x8 #(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [2:0]       code,
    input  logic             code_v,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out,
    output logic             out_valid,
    output logic             out_none,
    output logic [CNT_W-1:0] dec_cnt,
    output logic             o_dbg_state
);

    // Handshake: a transfer happens on a rising edge where in_valid && in_ready; in_ready is
    // derived from state, hold counter and buffer only, and in_valid may wait on in_ready.
    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;

    localparam logic [7:0] HOLD_INIT = 8'(HOLD_CYCLES - 1);

    state_t           r_state;
    state_t           w_next_state;
    logic [7:0]       r_hold_cnt;
    logic [7:0]       r_out;
    logic             r_out_valid;
    logic             r_out_none;
    logic [CNT_W-1:0] r_dec_cnt;

    logic             w_xfer;
    logic             w_cnt_zero;
    logic             w_pending;
    logic             w_load;
    logic             w_in_ready;
    logic [2:0]       w_src_code;
    logic             w_src_v;
    logic [7:0]       w_pattern;

    assign w_xfer     = in_valid && w_in_ready;
    assign w_cnt_zero = (r_hold_cnt == 8'd0);

`ifdef PRIORITY_DECODER_BUFFER_EN
    logic       r_buf_full;
    logic [2:0] r_buf_code;
    logic       r_buf_v;
    logic       w_buf_wr;
    logic       w_buf_rd;

    assign w_buf_wr   = w_xfer && (r_state == S_HOLD) && !w_cnt_zero;
    assign w_buf_rd   = (r_state == S_HOLD) && w_cnt_zero && r_buf_full;
    assign w_in_ready = (r_state == S_IDLE) || !r_buf_full;
    assign w_pending  = r_buf_full || w_xfer;
    // A buffered entry always wins at the end of a hold; in_ready is low then anyway.
    assign w_src_code = r_buf_full ? r_buf_code : code;
    assign w_src_v    = r_buf_full ? r_buf_v : code_v;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_buf_full <= 1'b0;
            r_buf_code <= 3'd0;
            r_buf_v    <= 1'b0;
        end else if (w_buf_wr) begin
            r_buf_full <= 1'b1;
            r_buf_code <= code;
            r_buf_v    <= code_v;
        end else if (w_buf_rd) begin
            r_buf_full <= 1'b0;
        end
    end
`else
    assign w_in_ready = (r_state == S_IDLE) || w_cnt_zero;
    assign w_pending  = w_xfer;
    assign w_src_code = code;
    assign w_src_v    = code_v;
`endif

    assign w_load = (r_state == S_IDLE) ? w_xfer : (w_cnt_zero && w_pending);

    always_comb begin
        w_pattern = 8'h00;
        if (w_src_v) begin
            w_pattern[w_src_code] = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE: if (w_xfer) w_next_state = S_HOLD;
            S_HOLD: if (w_cnt_zero && !w_pending) w_next_state = S_IDLE;
            default: w_next_state = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready    = w_in_ready;
        out         = r_out;
        out_valid   = r_out_valid;
        out_none    = r_out_none;
        dec_cnt     = r_dec_cnt;
        o_dbg_state = r_state;
    end

    // Pattern register and hold counter; a reload at cnt==0 leaves no gap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out       <= 8'h00;
            r_out_valid <= 1'b0;
            r_out_none  <= 1'b0;
            r_hold_cnt  <= 8'd0;
        end else if (w_load) begin
            r_out       <= w_pattern;
            r_out_valid <= 1'b1;
            r_out_none  <= !w_src_v;
            r_hold_cnt  <= HOLD_INIT;
        end else if (r_state == S_HOLD) begin
            if (w_cnt_zero) begin
                r_out       <= 8'h00;
                r_out_valid <= 1'b0;
                r_out_none  <= 1'b0;
            end else begin
                r_hold_cnt <= r_hold_cnt - 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_dec_cnt <= '0;
        end else if (w_xfer && (r_dec_cnt != {CNT_W{1'b1}})) begin
            r_dec_cnt <= r_dec_cnt + CNT_W'(1);
        end
    end

endmodule

// File: doc/priority_decoder_3x8.md
# priority_decoder_3x8

- Sequential 3-to-8 decoder for the receive end of an encoded request channel.
- Accepts a 3-bit index plus its valid flag from the upstream 8x3 priority encoder and drives the matching one-hot line for a programmable number of cycles.
- A code flagged invalid produces an all-zero pulse.
- Sits between the encoded channel and the per-line consumers (interrupt or grant lines); accepted decodes are counted for debug.

## Interface

Parameters:
- HOLD_CYCLES, default 4, cycles each decoded pattern is held on `out`; legal range 1..255.
- CNT_W, default 16, width of the saturating decode counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  reset; one clock, reset is asynchronous and active-low.
- code  input  3  encoded index, 0..7.
- code_v  input  1  encoder valid flag; 0 means "no line active".
- in_valid  input  1  a code/code_v pair is presented.
- in_ready  output  1  block can accept this cycle.
- out  output  8  one-hot decoded line, registered.
- out_valid  output  1  `out` carries a decoded pattern.
- out_none  output  1  current pattern came from code_v=0.
- dec_cnt  output  CNT_W  accepted transfers, saturating.

## Operation

- Transfer occurs on any rising edge with in_valid && in_ready.
- Decode rule:
  - `out` = 8'b1 << code when code_v=1.
  - `out` = 8'h00 and out_none=1 when code_v=0; `code` is ignored.
- FSM, two states:
  - IDLE: out=0, out_valid=0, out_none=0, in_ready=1. A transfer loads the decoded pattern, sets out_valid=1, loads hold counter with HOLD_CYCLES-1 and goes to HOLD.
  - HOLD: out, out_none and out_valid are stable; the counter decrements each cycle.
    - cnt!=0: in_ready=0 (no buffer build).
    - cnt==0 with a pending transfer (direct, or buffered when enabled): reload the pattern and counter, stay in HOLD, with no gap cycle.
    - cnt==0 with no pending transfer: go to IDLE and clear out/out_valid/out_none.
- dec_cnt increments on every transfer, including code_v=0, and saturates at all-ones.
- Asynchronous reset mid-hold: all outputs clear immediately, FSM returns to IDLE, any buffered entry is discarded.
- With HOLD_CYCLES=1, every HOLD cycle is the cnt==0 cycle, so in_ready stays 1 and back-to-back transfers stream one per cycle.

## Timing

- Reset values: out=8'h00, out_valid=0, out_none=0, dec_cnt=0, FSM=IDLE, in_ready=1 once rst_n deasserts.
- Latency: a pattern appears on `out` the cycle after the accepting edge.
- Each pattern is held exactly HOLD_CYCLES cycles, then replaced by the next pattern or cleared.
- Throughput: one transfer per HOLD_CYCLES cycles at best.
- `out` never carries more than one asserted bit.
- in_ready is combinational from state, the counter and the buffer only; it never depends on in_valid.

## Configuration

- Macro: PRIORITY_DECODER_BUFFER_EN.
- Defined: adds a one-entry input buffer (code, code_v).
  - In HOLD, in_ready = !buf_full, so one transfer can be taken while a pattern is held.
  - At cnt==0 the buffered entry loads with priority and the buffer empties; in_ready is 0 that cycle because the buffer was full.
  - An empty buffer at cnt==0 behaves as in the undefined case.
  - The buffer is always empty in IDLE.
- Undefined: no buffer; in_ready is exactly as described in Operation.

## Test plan

- Reset, then transfer code=5, code_v=1 at HOLD_CYCLES=4 -> out=8'h20, out_valid=1 for exactly 4 cycles starting the cycle after accept, then out=0; dec_cnt=1.
- Transfer code=3, code_v=0 -> out=8'h00, out_valid=1, out_none=1 for 4 cycles; dec_cnt increments.
- Hold in_valid high and step code 0..7, buffer undefined -> in_ready high only in IDLE and on cnt==0 cycles; patterns 8'h01..8'h80 appear back-to-back, each held 4 cycles with no gap.
- With PRIORITY_DECODER_BUFFER_EN, send code=1 and then code=6 one cycle later -> second transfer accepted during HOLD; 8'h02 held 4 cycles, then 8'h40 held 4 cycles; in_ready=0 while the buffer is full.
- Assert rst_n=0 two cycles into a hold of code=7 -> out, out_valid and dec_cnt go to 0 without waiting for a clock edge; after release the block is in IDLE with in_ready=1.
- Set CNT_W=2 and run 5 transfers -> dec_cnt stops at 3.
